lsu_align: RTL

- Load/store unit between the MEM pipeline stage and the synchronous memory data port (addrD/renD/rdataD/wenD/wdataD/MaskD, 1-cycle registered read).
- Converts RV32I load/store requests (funct3-encoded size and sign) into word-addressed memory accesses with byte masks.
- Lane-shifts store data, extracts and sign/zero-extends load data, and flags misaligned or illegal accesses.
- Presents a valid/ready request side and a single-cycle response pulse to the pipeline.

---
 rtl/lsu_align_if.sv | 37 +++
 rtl/lsu_align.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/lsu_align_if.sv
// lsu_align_if: bundles the pipeline request/response handshake and the
// synchronous memory data port of the load/store unit.
//   master : pipeline/memory side (drives requests and read data)
//   slave  : lsu_align side (drives ready, memory controls, responses)
// Signals:
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata : request
//   addrD/renD/wenD/wdataD/MaskD/rdataD                      : memory port
//   resp_valid/resp_rdata/resp_err                           : response
interface lsu_align_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] addrD;
  logic        renD;
  logic        wenD;
  logic [31:0] wdataD;
  logic [3:0]  MaskD;
  logic [31:0] rdataD;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rdataD,
    input  req_ready, addrD, renD, wenD, wdataD, MaskD,
           resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rdataD,
    output req_ready, addrD, renD, wenD, wdataD, MaskD,
           resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: RV32I load/store alignment unit between the MEM stage and a
// word-wide synchronous memory with 1-cycle registered read.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : lsu_align_if.slave (request handshake, memory port, response)
// Parameter:
//   MISALIGN_TRAP : 1 = misaligned access answered with resp_err,
//                   0 = low address bits forced to natural alignment.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | ready for a request; memory controls driven from req_*
// LOAD_WAIT | read issued, extract/extend rdataD into the response
// RESP      | one-cycle response pulse, then back to IDLE
module lsu_align #(
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  lsu_align_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  ld_f3, ld_f3_nxt;
  logic [1:0]  ld_off, ld_off_nxt;
  logic        err_q, err_nxt;
  logic [31:0] rdata_q, rdata_nxt;

  logic [1:0]  size;
  logic        legal;
  logic        misal;
  logic        req_err;
  logic [1:0]  off;
  logic [31:0] shifted;
  logic [31:0] ld_ext;

  logic        ready;
  logic        ren;
  logic        wen;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic [3:0]  mask_o;

  // Request decode: legality, alignment and effective byte offset.
  always_comb begin
    size  = bus.req_funct3[1:0];
    if (bus.req_we)
      legal = !bus.req_funct3[2] && (size != 2'b11);
    else
      legal = (size != 2'b11) && !(bus.req_funct3[2] && size == 2'b10);
    misal   = (size == 2'b01 && bus.req_addr[0]) ||
              (size == 2'b10 && bus.req_addr[1:0] != 2'b00);
    req_err = !legal || (MISALIGN_TRAP && misal);
    // Halfword/word offsets are masked down; when trapping, a misaligned
    // request never reaches memory so the masking is harmless.
    case (size)
      2'b01:   off = {bus.req_addr[1], 1'b0};
      2'b10:   off = 2'b00;
      default: off = bus.req_addr[1:0];
    endcase
  end

  // Load extraction from the latched offset and funct3.
  always_comb begin
    shifted = bus.rdataD >> {ld_off, 3'b000};
    case (ld_f3)
      3'b000:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld_ext = {24'h0, shifted[7:0]};
      3'b001:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ld_ext = {16'h0, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ld_f3   <= 3'b000;
      ld_off  <= 2'b00;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state   <= state_nxt;
      ld_f3   <= ld_f3_nxt;
      ld_off  <= ld_off_nxt;
      err_q   <= err_nxt;
      rdata_q <= rdata_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ld_f3_nxt  = ld_f3;
    ld_off_nxt = ld_off;
    err_nxt    = 1'b0;
    rdata_nxt  = 32'h0;
    ready      = 1'b0;
    ren        = 1'b0;
    wen        = 1'b0;
    addr_o     = 32'h0;
    wdata_o    = 32'h0;
    mask_o     = 4'b0000;

    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.req_valid) begin
          state_nxt = RESP;
          if (req_err) begin
            err_nxt = 1'b1;
          end else begin
            addr_o = {bus.req_addr[31:2], 2'b00};
            if (bus.req_we) begin
              wen = 1'b1;
              case (size)
                2'b00: begin
                  wdata_o = {4{bus.req_wdata[7:0]}};
                  mask_o  = 4'b0001 << off;
                end
                2'b01: begin
                  wdata_o = {2{bus.req_wdata[15:0]}};
                  mask_o  = off[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                  wdata_o = bus.req_wdata;
                  mask_o  = 4'b1111;
                end
              endcase
            end else begin
              ren        = 1'b1;
              ld_f3_nxt  = bus.req_funct3;
              ld_off_nxt = off;
              state_nxt  = LOAD_WAIT;
            end
          end
        end
      end
      LOAD_WAIT: begin
        rdata_nxt = ld_ext;
        state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Keep the memory quiet while reset is asserted, whatever the state.
    if (!rst_n) begin
      ren     = 1'b0;
      wen     = 1'b0;
      addr_o  = 32'h0;
      wdata_o = 32'h0;
      mask_o  = 4'b0000;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.renD       = ren;
  assign bus.wenD       = wen;
  assign bus.addrD      = addr_o;
  assign bus.wdataD     = wdata_o;
  assign bus.MaskD      = mask_o;
  // err_q/rdata_q are only ever loaded on the transition into RESP and
  // cleared on the way out, so they read as 0 outside the response pulse.
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = err_q;
  assign bus.resp_rdata = rdata_q;

endmodule
